// File: rtl/gemm_result_drain_if.sv
// rtl/gemm_result_drain_if.sv - result tile stream port (valid/ready, row-major words)
interface gemm_result_drain_if #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int DW   = 20
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [RW-1:0] out_row;
  logic [CW-1:0] out_col;

  modport master (
    output out_valid,
    output out_data,
    output out_row,
    output out_col,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_row,
    input  out_col,
    output out_ready
  );
endinterface

// File: rtl/gemm_result_drain.sv
// rtl/gemm_result_drain.sv - captures the systolic array drain into a tile and streams it row-major
module gemm_result_drain #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int DW   = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sync_reset,
  input  logic [1:0]           state,
  input  logic [ROWS*DW-1:0]   row_result,
  input  logic [ROWS-1:0]      row_valid,
  gemm_result_drain_if.master  out,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_READOUT = 2'd2
  } fsm_e;

  fsm_e            fsm_q, fsm_d;
  logic [ROWS-1:0] prev_valid_q, prev_valid_d;
  logic [ROWS-1:0] cap_active_q, cap_active_d;
  logic [ROWS-1:0] row_done_q, row_done_d;
  logic [CW-1:0]   cap_cnt_q [ROWS];
  logic [CW-1:0]   cap_cnt_d [ROWS];
  logic [DW-1:0]   tile_q [ROWS][COLS];
  logic [DW-1:0]   tile_d [ROWS][COLS];
  logic            out_valid_q, out_valid_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic [RW-1:0]   out_row_q, out_row_d;
  logic [CW-1:0]   out_col_q, out_col_d;
  logic            done_q, done_d;
  logic            overflow_q, overflow_d;

  logic [ROWS-1:0] drain_evt;
  logic            clear_done;
  logic            accept;
  logic            last_word;
  logic [RW-1:0]   next_row;
  logic [CW-1:0]   next_col;

  // A falling gemm_valid2 while in GEMM mode marks the start of that row's shift-out.
  assign drain_evt = prev_valid_q & ~row_valid & {ROWS{state == 2'b00}};

  // Per-row capture: word k lands in column COLS-1-k, rows run independently of each other.
  always_comb begin
    prev_valid_d = row_valid;
    cap_active_d = cap_active_q;
    row_done_d   = row_done_q;
    cap_cnt_d    = cap_cnt_q;
    tile_d       = tile_q;
    for (int r = 0; r < ROWS; r++) begin
      if (cap_active_q[r]) begin
        tile_d[r][CW'(COLS-1) - cap_cnt_q[r]] = row_result[r*DW +: DW];
        if (cap_cnt_q[r] == CW'(COLS-1)) begin
          cap_active_d[r] = 1'b0;
          row_done_d[r]   = 1'b1;
        end else begin
          cap_cnt_d[r] = cap_cnt_q[r] + 1'b1;
        end
      end else if (drain_evt[r] && !row_done_q[r] && fsm_q != S_READOUT) begin
        tile_d[r][COLS-1] = row_result[r*DW +: DW];
        if (COLS == 1) begin
          row_done_d[r] = 1'b1;
        end else begin
          cap_active_d[r] = 1'b1;
          cap_cnt_d[r]    = CW'(1);
        end
      end
    end
    if (clear_done) begin
      row_done_d = '0;
    end
    if (sync_reset) begin
      prev_valid_d = '0;
      cap_active_d = '0;
      row_done_d   = '0;
      for (int r = 0; r < ROWS; r++) begin
        cap_cnt_d[r] = '0;
        for (int c = 0; c < COLS; c++) begin
          tile_d[r][c] = '0;
        end
      end
    end
  end

  // Control FSM and row-major readout; the output word is registered and held while stalled.
  always_comb begin
    fsm_d       = fsm_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    done_d      = 1'b0;
    overflow_d  = overflow_q | ((fsm_q == S_READOUT) && (|drain_evt));
    clear_done  = 1'b0;
    accept      = out_valid_q && out.out_ready;
    last_word   = (out_row_q == RW'(ROWS-1)) && (out_col_q == CW'(COLS-1));
    next_row    = out_row_q;
    next_col    = out_col_q + 1'b1;
    if (out_col_q == CW'(COLS-1)) begin
      next_row = out_row_q + 1'b1;
      next_col = '0;
    end
    case (fsm_q)
      S_IDLE: begin
        if (|drain_evt) begin
          fsm_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (&row_done_q) begin
          fsm_d       = S_READOUT;
          out_valid_d = 1'b1;
          out_row_d   = '0;
          out_col_d   = '0;
          out_data_d  = tile_q[0][0];
        end
      end
      S_READOUT: begin
        if (accept) begin
          if (last_word) begin
            fsm_d       = S_IDLE;
            out_valid_d = 1'b0;
            out_row_d   = '0;
            out_col_d   = '0;
            out_data_d  = '0;
            done_d      = 1'b1;
            clear_done  = 1'b1;
          end else begin
            out_row_d  = next_row;
            out_col_d  = next_col;
            out_data_d = tile_q[next_row][next_col];
          end
        end
      end
      default: begin
        fsm_d = S_IDLE;
      end
    endcase
    if (sync_reset) begin
      fsm_d       = S_IDLE;
      out_valid_d = 1'b0;
      out_data_d  = '0;
      out_row_d   = '0;
      out_col_d   = '0;
      done_d      = 1'b0;
      overflow_d  = 1'b0;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q        <= S_IDLE;
      prev_valid_q <= '0;
      cap_active_q <= '0;
      row_done_q   <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        cap_cnt_q[r] <= '0;
        for (int c = 0; c < COLS; c++) begin
          tile_q[r][c] <= '0;
        end
      end
    end else begin
      fsm_q        <= fsm_d;
      prev_valid_q <= prev_valid_d;
      cap_active_q <= cap_active_d;
      row_done_q   <= row_done_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_row_q    <= out_row_d;
      out_col_q    <= out_col_d;
      done_q       <= done_d;
      overflow_q   <= overflow_d;
      cap_cnt_q    <= cap_cnt_d;
      tile_q       <= tile_d;
    end
  end

  assign out.out_valid = out_valid_q;
  assign out.out_data  = out_data_q;
  assign out.out_row   = out_row_q;
  assign out.out_col   = out_col_q;
  assign busy          = (fsm_q != S_IDLE);
  assign done          = done_q;
  assign overflow      = overflow_q;
endmodule
